// File: rtl/issue_scheduler_pkg.sv
// Shared encodings for the issue scheduler: opcodes, scheduler states, unit ids
// and the opcode decode that says which operands an instruction uses.
package issue_scheduler_pkg;

    localparam int unsigned LEN_REG_ADDR = 6;
    localparam int unsigned LEN_SB       = 64;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_MEML   = 7'b0000011;
    localparam logic [6:0] OP_MEMS   = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_FMEML  = 7'b0000111;
    localparam logic [6:0] OP_FMEMS  = 7'b0100111;
    localparam logic [6:0] OP_FPU    = 7'b1010011;
    localparam logic [6:0] OP_INPUT  = 7'b0001011;
    localparam logic [6:0] OP_OUTPUT = 7'b0101011;

    typedef enum logic [1:0] {S_RUN, S_WAIT_CTRL, S_WAIT_IO} sched_state_t;
    typedef enum logic [2:0] {U_NONE, U_ALU, U_FPU, U_MEM, U_CTRL, U_IO} unit_t;

    typedef struct packed {
        logic  legal;
        logic  use_rs1;
        logic  use_rs2;
        logic  use_rd;
        unit_t unit;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [6:0] op);
        op_info_t info;
        info = '0;
        unique case (op)
            OP_ALU:             info = '{1'b1, 1'b1, 1'b1, 1'b1, U_ALU};
            OP_ALUI:            info = '{1'b1, 1'b1, 1'b0, 1'b1, U_ALU};
            OP_LUI, OP_AUIPC:   info = '{1'b1, 1'b0, 1'b0, 1'b1, U_ALU};
            OP_FPU:             info = '{1'b1, 1'b1, 1'b1, 1'b1, U_FPU};
            OP_MEML, OP_FMEML:  info = '{1'b1, 1'b1, 1'b0, 1'b1, U_MEM};
            OP_MEMS, OP_FMEMS:  info = '{1'b1, 1'b1, 1'b1, 1'b0, U_MEM};
            OP_JAL:             info = '{1'b1, 1'b0, 1'b0, 1'b1, U_CTRL};
            OP_JALR:            info = '{1'b1, 1'b1, 1'b0, 1'b1, U_CTRL};
            OP_BRANCH:          info = '{1'b1, 1'b1, 1'b1, 1'b0, U_CTRL};
            OP_INPUT:           info = '{1'b1, 1'b0, 1'b0, 1'b1, U_IO};
            OP_OUTPUT:          info = '{1'b1, 1'b1, 1'b0, 1'b0, U_IO};
            default:            info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode/issue/writeback bundle between the scheduler (slave) and its
// surrounding pipeline (master).
interface issue_scheduler_if
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned NUM_WB = 2
);
    logic                         dec_valid;
    logic                         dec_ready;
    logic [6:0]                   dec_opecode;
    logic [LEN_REG_ADDR-1:0]      dec_a_rs1;
    logic [LEN_REG_ADDR-1:0]      dec_a_rs2;
    logic [LEN_REG_ADDR-1:0]      dec_a_rd;
    logic                         alu_ready, fpu_ready, mem_ready, ctrl_ready, io_ready;
    logic                         iss_alu, iss_fpu, iss_mem, iss_ctrl, iss_io;
    logic [NUM_WB-1:0]            wb_valid;
    logic [LEN_REG_ADDR*NUM_WB-1:0] wb_a_rd;
    logic                         mem_done, ctrl_done, io_done;
    logic                         stall;
    logic                         illegal_op;
    logic [LEN_SB-1:0]            busy_vec;

    modport slave (
        input  dec_valid, dec_opecode, dec_a_rs1, dec_a_rs2, dec_a_rd,
        input  alu_ready, fpu_ready, mem_ready, ctrl_ready, io_ready,
        input  wb_valid, wb_a_rd, mem_done, ctrl_done, io_done,
        output dec_ready, iss_alu, iss_fpu, iss_mem, iss_ctrl, iss_io,
        output stall, illegal_op, busy_vec
    );

    modport master (
        output dec_valid, dec_opecode, dec_a_rs1, dec_a_rs2, dec_a_rd,
        output alu_ready, fpu_ready, mem_ready, ctrl_ready, io_ready,
        output wb_valid, wb_a_rd, mem_done, ctrl_done, io_done,
        input  dec_ready, iss_alu, iss_fpu, iss_mem, iss_ctrl, iss_io,
        input  stall, illegal_op, busy_vec
    );
endinterface

// File: rtl/issue_scheduler_scoreboard.sv
// 64-entry register busy scoreboard: NUM_WB clear ports, one set port,
// three read ports. x0 is never busy; a same-cycle set beats any clear.
module reg_scoreboard
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned NUM_WB = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_WB-1:0]              clr_valid,
    input  logic [LEN_REG_ADDR*NUM_WB-1:0] clr_addr,
    input  logic                           set_valid,
    input  logic [LEN_REG_ADDR-1:0]        set_addr,
    input  logic [LEN_REG_ADDR-1:0]        rs1_addr,
    input  logic [LEN_REG_ADDR-1:0]        rs2_addr,
    input  logic [LEN_REG_ADDR-1:0]        rd_addr,
    output logic                           rs1_busy,
    output logic                           rs2_busy,
    output logic                           rd_busy,
    output logic [LEN_SB-1:0]              busy_vec
);
    logic [LEN_SB-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_vec;
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            if (clr_valid[k]) begin
                busy_nxt[clr_addr[LEN_REG_ADDR*k +: LEN_REG_ADDR]] = 1'b0;
            end
        end
        if (set_valid) begin
            busy_nxt[set_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

    assign rs1_busy = (rs1_addr != '0) && busy_vec[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) && busy_vec[rs2_addr];
    assign rd_busy  = (rd_addr  != '0) && busy_vec[rd_addr];

endmodule

// File: rtl/issue_scheduler.sv
// Issues one decoded instruction per cycle to a single execution unit, holding
// it on register hazards, serialised control/IO, or a full memory window.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned NUM_WB  = 2,
    parameter int unsigned MAX_MEM = 4
) (
    input  logic              clk,
    input  logic              rstn,
    issue_scheduler_if.slave  bus
);
    sched_state_t state, state_nxt;
    logic [3:0]   mem_cnt;
    logic         illegal_q;
    op_info_t     info;
    logic         rs1_busy, rs2_busy, rd_busy;
    logic         hazard, unit_ready, extra, run, fire, drop;
    logic [LEN_SB-1:0] busy_vec;

    assign info = decode_op(bus.dec_opecode);
    // Gated by rstn so every handshake output is quiet while reset is held.
    assign run  = rstn && (state == S_RUN);

    reg_scoreboard #(.NUM_WB(NUM_WB)) u_scoreboard (
        .clk       (clk),
        .rstn      (rstn),
        .clr_valid (bus.wb_valid),
        .clr_addr  (bus.wb_a_rd),
        .set_valid (fire && info.use_rd),
        .set_addr  (bus.dec_a_rd),
        .rs1_addr  (bus.dec_a_rs1),
        .rs2_addr  (bus.dec_a_rs2),
        .rd_addr   (bus.dec_a_rd),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rd_busy   (rd_busy),
        .busy_vec  (busy_vec)
    );

    always_comb begin
        hazard = (info.use_rs1 && rs1_busy) || (info.use_rs2 && rs2_busy) ||
                 (info.use_rd && rd_busy);
        unit_ready = 1'b0;
        extra      = 1'b1;
        unique case (info.unit)
            U_ALU:  unit_ready = bus.alu_ready;
            U_FPU:  unit_ready = bus.fpu_ready;
            U_MEM:  begin
                unit_ready = bus.mem_ready;
                extra      = mem_cnt < 4'(MAX_MEM);
            end
            U_CTRL: unit_ready = bus.ctrl_ready;
            U_IO:   begin
                unit_ready = bus.io_ready;
                extra      = (busy_vec == '0) && (mem_cnt == '0);
            end
            default: unit_ready = 1'b0;
        endcase
        fire = bus.dec_valid && run && info.legal && !hazard && unit_ready && extra;
        drop = bus.dec_valid && run && !info.legal;
    end

    assign bus.dec_ready  = fire || drop;
    assign bus.iss_alu    = fire && (info.unit == U_ALU);
    assign bus.iss_fpu    = fire && (info.unit == U_FPU);
    assign bus.iss_mem    = fire && (info.unit == U_MEM);
    assign bus.iss_ctrl   = fire && (info.unit == U_CTRL);
    assign bus.iss_io     = fire && (info.unit == U_IO);
    assign bus.stall      = rstn && bus.dec_valid && !bus.dec_ready;
    assign bus.illegal_op = illegal_q;
    assign bus.busy_vec   = busy_vec;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RUN: begin
                if (fire && info.unit == U_CTRL)    state_nxt = S_WAIT_CTRL;
                else if (fire && info.unit == U_IO) state_nxt = S_WAIT_IO;
            end
            S_WAIT_CTRL: if (bus.ctrl_done) state_nxt = S_RUN;
            S_WAIT_IO:   if (bus.io_done)   state_nxt = S_RUN;
            default:     state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_RUN;
            mem_cnt   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            illegal_q <= drop;
            // A retire at zero is spurious and must not wrap the counter.
            if (bus.iss_mem && !(bus.mem_done && mem_cnt != '0)) begin
                mem_cnt <= mem_cnt + 4'd1;
            end else if (!bus.iss_mem && bus.mem_done && mem_cnt != '0) begin
                mem_cnt <= mem_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// behavioural model of the issue rules.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    localparam int NWB  = 2;
    localparam int MAXM = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    issue_scheduler_if #(.NUM_WB(NWB)) bus ();

    issue_scheduler #(.NUM_WB(NWB), .MAX_MEM(MAXM)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit [63:0] m_busy = '0;
    int        m_cnt  = 0;
    int        m_mode = 0;   // 0 run, 1 waiting on branch, 2 waiting on IO
    bit        m_ill  = 1'b0;

    logic       o_ready, o_stall;
    logic [4:0] o_iss;       // {alu, fpu, mem, ctrl, io}

    logic [6:0] ops [15] = '{OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC, OP_FPU, OP_MEML, OP_FMEML,
                             OP_MEMS, OP_FMEMS, OP_JAL, OP_JALR, OP_BRANCH, OP_INPUT,
                             OP_OUTPUT, 7'h7F};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op_props(input logic [6:0] op, output bit legal, output bit r1,
                            output bit r2, output bit rd, output int unit);
        {legal, r1, r2, rd} = 4'b0000;
        unit = 0;
        case (op)
            OP_ALU:            begin {legal, r1, r2, rd} = 4'b1111; unit = 1; end
            OP_ALUI:           begin {legal, r1, r2, rd} = 4'b1101; unit = 1; end
            OP_LUI, OP_AUIPC:  begin {legal, r1, r2, rd} = 4'b1001; unit = 1; end
            OP_FPU:            begin {legal, r1, r2, rd} = 4'b1111; unit = 2; end
            OP_MEML, OP_FMEML: begin {legal, r1, r2, rd} = 4'b1101; unit = 3; end
            OP_MEMS, OP_FMEMS: begin {legal, r1, r2, rd} = 4'b1110; unit = 3; end
            OP_JAL:            begin {legal, r1, r2, rd} = 4'b1001; unit = 4; end
            OP_JALR:           begin {legal, r1, r2, rd} = 4'b1101; unit = 4; end
            OP_BRANCH:         begin {legal, r1, r2, rd} = 4'b1110; unit = 4; end
            OP_INPUT:          begin {legal, r1, r2, rd} = 4'b1001; unit = 5; end
            OP_OUTPUT:         begin {legal, r1, r2, rd} = 4'b1100; unit = 5; end
            default:           begin {legal, r1, r2, rd} = 4'b0000; unit = 0; end
        endcase
    endtask

    function automatic bit m_isbusy(input logic [5:0] a);
        return (a != 6'd0) && m_busy[a];
    endfunction

    task automatic set_idle();
        bus.dec_valid = 1'b0; bus.dec_opecode = OP_ALU;
        bus.dec_a_rs1 = '0; bus.dec_a_rs2 = '0; bus.dec_a_rd = '0;
        {bus.alu_ready, bus.fpu_ready, bus.mem_ready, bus.ctrl_ready, bus.io_ready} = 5'b11111;
        bus.wb_valid = '0; bus.wb_a_rd = '0;
        bus.mem_done = 1'b0; bus.ctrl_done = 1'b0; bus.io_done = 1'b0;
    endtask

    task automatic set_op(input logic [6:0] op, input logic [5:0] rs1, input logic [5:0] rs2,
                          input logic [5:0] rd);
        bus.dec_valid = 1'b1; bus.dec_opecode = op;
        bus.dec_a_rs1 = rs1; bus.dec_a_rs2 = rs2; bus.dec_a_rd = rd;
    endtask

    // Entered at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic cycle();
        bit legal, u1, u2, ud, haz, rdy, ok, fire, acc, dn;
        int unit, nc, nm;
        logic [4:0] eiss;
        bit [63:0] nb;
        #3;
        op_props(bus.dec_opecode, legal, u1, u2, ud, unit);
        haz = (u1 && m_isbusy(bus.dec_a_rs1)) || (u2 && m_isbusy(bus.dec_a_rs2)) ||
              (ud && m_isbusy(bus.dec_a_rd));
        case (unit)
            1: rdy = bus.alu_ready;
            2: rdy = bus.fpu_ready;
            3: rdy = bus.mem_ready;
            4: rdy = bus.ctrl_ready;
            5: rdy = bus.io_ready;
            default: rdy = 1'b0;
        endcase
        ok = 1'b1;
        if (unit == 3) ok = (m_cnt < MAXM);
        if (unit == 5) ok = (m_busy == '0) && (m_cnt == 0);
        fire = rstn && bus.dec_valid && m_mode == 0 && legal && !haz && rdy && ok;
        dn   = rstn && bus.dec_valid && m_mode == 0 && !legal;
        acc  = fire || dn;
        eiss = fire ? 5'(5'b10000 >> (unit - 1)) : 5'b00000;
        o_ready = bus.dec_ready;
        o_stall = bus.stall;
        o_iss   = {bus.iss_alu, bus.iss_fpu, bus.iss_mem, bus.iss_ctrl, bus.iss_io};
        chk("dec_ready", o_ready, acc);
        chk("iss_vec", o_iss, eiss);
        chk("stall", o_stall, rstn && bus.dec_valid && !acc);

        nb = m_busy;
        for (int k = 0; k < NWB; k++) begin
            if (bus.wb_valid[k]) nb[bus.wb_a_rd[6*k +: 6]] = 1'b0;
        end
        if (fire && ud) nb[bus.dec_a_rd] = 1'b1;
        nb[0] = 1'b0;
        nc = m_cnt + ((fire && unit == 3) ? 1 : 0) - ((bus.mem_done && m_cnt > 0) ? 1 : 0);
        nm = m_mode;
        if (m_mode == 0 && fire && unit == 4) nm = 1;
        else if (m_mode == 0 && fire && unit == 5) nm = 2;
        else if (m_mode == 1 && bus.ctrl_done) nm = 0;
        else if (m_mode == 2 && bus.io_done) nm = 0;
        if (!rstn) begin nb = '0; nc = 0; nm = 0; dn = 1'b0; end

        @(posedge clk);
        #1;
        m_busy = nb; m_cnt = nc; m_mode = nm; m_ill = dn;
        chk("busy_vec", bus.busy_vec, m_busy);
        chk("illegal_op", bus.illegal_op, m_ill);
    endtask

    task automatic clear_reg(input logic [5:0] a);
        set_idle();
        bus.wb_valid = 2'b01;
        bus.wb_a_rd  = {6'd0, a};
        cycle();
        set_idle();
    endtask

    initial begin
        logic [5:0] r1, r2, rd, w0, w1;
        set_idle();
        set_op(OP_ALU, 6'd1, 6'd2, 6'd3);
        repeat (2) @(posedge clk);
        #4;
        chk("rst_busy", bus.busy_vec, 64'd0);
        chk("rst_ready", bus.dec_ready, 1'b0);
        chk("rst_iss", {bus.iss_alu, bus.iss_fpu, bus.iss_mem, bus.iss_ctrl, bus.iss_io}, 5'd0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_illegal", bus.illegal_op, 1'b0);
        set_idle();
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1: RAW stall, no writeback bypass
        set_op(OP_ALU, 6'd1, 6'd2, 6'd5); cycle(); chk("t1_first", o_iss[4], 1'b1);
        set_op(OP_ALU, 6'd5, 6'd2, 6'd6); cycle(); chk("t1_raw_stall", o_stall, 1'b1);
        bus.wb_valid = 2'b01; bus.wb_a_rd = {6'd0, 6'd5};
        cycle(); chk("t1_no_bypass", o_stall, 1'b1);
        bus.wb_valid = 2'b00; cycle(); chk("t1_issue", o_iss[4], 1'b1);
        clear_reg(6'd6);

        // 2: WAW on f3, then clear and set of f3 in one cycle
        set_op(OP_FPU, 6'd33, 6'd34, 6'd35); cycle(); chk("t2_busy", bus.busy_vec[35], 1'b1);
        bus.wb_valid = 2'b10; bus.wb_a_rd = {6'd35, 6'd0};
        cycle(); chk("t2_waw_stall", o_stall, 1'b1);
        cycle(); chk("t2_issue", o_iss[3], 1'b1); chk("t2_set_wins", bus.busy_vec[35], 1'b1);
        clear_reg(6'd35);

        // 3: memory window
        for (int i = 0; i < 5; i++) begin
            set_op(OP_MEML, 6'd1, 6'd0, 6'(10 + i)); cycle();
            chk("t3_mem_iss", o_iss[2], i < MAXM);
        end
        bus.mem_done = 1'b1; cycle(); chk("t3_full", o_stall, 1'b1);
        bus.mem_done = 1'b0; cycle(); chk("t3_after_done", o_iss[2], 1'b1);
        set_idle(); bus.mem_done = 1'b1; repeat (5) cycle();
        for (int i = 10; i < 15; i++) clear_reg(6'(i));

        // 4: branch serialisation
        set_op(OP_BRANCH, 6'd1, 6'd2, 6'd0); cycle(); chk("t4_ctrl", o_iss[1], 1'b1);
        set_op(OP_ALU, 6'd1, 6'd2, 6'd8);
        for (int i = 0; i < 3; i++) begin cycle(); chk("t4_held", o_iss[4], 1'b0); end
        bus.ctrl_done = 1'b1; cycle(); chk("t4_done_cycle", o_iss[4], 1'b0);
        bus.ctrl_done = 1'b0; cycle(); chk("t4_resume", o_iss[4], 1'b1);
        clear_reg(6'd8);

        // 5: IO waits for a quiet scoreboard
        set_op(OP_ALU, 6'd1, 6'd2, 6'd7); cycle();
        set_op(OP_OUTPUT, 6'd7, 6'd0, 6'd0); cycle(); chk("t5_held", o_stall, 1'b1);
        bus.wb_valid = 2'b01; bus.wb_a_rd = {6'd0, 6'd7}; cycle(); chk("t5_wb_cycle", o_iss[0], 1'b0);
        bus.wb_valid = 2'b00; cycle(); chk("t5_io", o_iss[0], 1'b1);
        set_op(OP_ALU, 6'd1, 6'd2, 6'd9); cycle(); chk("t5_wait_io", o_iss[4], 1'b0);
        bus.io_done = 1'b1; cycle(); chk("t5_done_cycle", o_iss[4], 1'b0);
        bus.io_done = 1'b0; cycle(); chk("t5_resume", o_iss[4], 1'b1);
        clear_reg(6'd9);

        // 6: x0, illegal opcode, reset mid-stall
        set_op(OP_ALU, 6'd1, 6'd2, 6'd0); cycle(); chk("t6_x0_unmarked", bus.busy_vec, 64'd0);
        set_op(OP_ALU, 6'd0, 6'd0, 6'd4); cycle(); chk("t6_x0_src", o_iss[4], 1'b1);
        clear_reg(6'd4);
        set_op(7'h7F, 6'd1, 6'd2, 6'd3); cycle();
        chk("t6_ill_accept", o_ready, 1'b1); chk("t6_ill_pulse", bus.illegal_op, 1'b1);
        set_idle(); cycle(); chk("t6_ill_end", bus.illegal_op, 1'b0);
        set_op(OP_ALU, 6'd1, 6'd2, 6'd9); cycle();
        set_op(OP_ALU, 6'd9, 6'd0, 6'd10); cycle(); chk("t6_stall", o_stall, 1'b1);
        rstn = 1'b0; #1;
        chk("t6_rst_busy", bus.busy_vec, 64'd0);
        chk("t6_rst_iss", {bus.iss_alu, bus.iss_fpu, bus.iss_mem, bus.iss_ctrl, bus.iss_io}, 5'd0);
        chk("t6_rst_stall", bus.stall, 1'b0);
        m_busy = '0; m_cnt = 0; m_mode = 0; m_ill = 1'b0;
        set_idle(); #2; rstn = 1'b1;
        @(posedge clk); #1;

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            r1 = 6'($urandom_range(0, 11)); if (r1 > 5) r1 = r1 + 6'd26;
            r2 = 6'($urandom_range(0, 11)); if (r2 > 5) r2 = r2 + 6'd26;
            rd = 6'($urandom_range(0, 11)); if (rd > 5) rd = rd + 6'd26;
            w0 = 6'($urandom_range(0, 11)); if (w0 > 5) w0 = w0 + 6'd26;
            w1 = 6'($urandom_range(0, 11)); if (w1 > 5) w1 = w1 + 6'd26;
            set_op(ops[$urandom_range(0, 14)], r1, r2, rd);
            bus.dec_valid  = ($urandom_range(0, 3) != 0);
            bus.alu_ready  = ($urandom_range(0, 4) != 0);
            bus.fpu_ready  = ($urandom_range(0, 4) != 0);
            bus.mem_ready  = ($urandom_range(0, 4) != 0);
            bus.ctrl_ready = ($urandom_range(0, 4) != 0);
            bus.io_ready   = ($urandom_range(0, 4) != 0);
            bus.wb_valid   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            bus.wb_a_rd    = {w1, w0};
            bus.mem_done   = ($urandom_range(0, 3) == 0);
            bus.ctrl_done  = ($urandom_range(0, 2) == 0);
            bus.io_done    = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
